regfile_wb_sink: RTL
====================

// Module: regfile_wb_sink
// PURPOSE
//  Architectural register file plus hazard scoreboard at the receiving end of the writeback interface.
//  Accepts one write per cycle from WB: write enable, 5-bit destination, 32-bit data.
//  Provides two combinational read ports to ID, with write-first bypass from the WB port.
//  Per-register pending-write counters raise `stall` when ID needs a source that has not been written back yet.
// PARAMETERS
//  NREG  32  number of architectural registers (r0 hardwired zero)
//  DW    32  data width
//  AW    5   register address width (clog2 NREG)
//  CW    2   pending-counter width; at most 2**CW-1 in-flight writes per register
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  wb_we       in   1   writeback write enable (regWrite from WB)
//  wb_waddr    in   AW  writeback destination register
//  wb_wdata    in   DW  writeback data
//  rs_addr     in   AW  read port A address
//  rt_addr     in   AW  read port B address
//  rs_use      in   1   ID instruction actually sources rs
//  rt_use      in   1   ID instruction actually sources rt
//  rs_data     out  DW  read port A data
//  rt_data     out  DW  read port B data
//  id_issue    in   1   ID wants to advance its instruction this cycle
//  id_dst_we   in   1   issuing instruction writes a register
//  id_dst      in   AW  issuing instruction's destination
//  stall       out  1   hold ID; issue is not accepted
//  dbg_addr    in   AW  debug read address
//  dbg_data    out  DW  debug read data, no bypass
//  sb_err      out  1   sticky scoreboard under/overflow flag
// BEHAVIOUR
//  - Reset, synchronous on rst=1: all regs=0, all counters=0, sb_err=0. stall=0 after reset.
//  - Read data reflects zeroed regs or bypass. rst dominates every same-cycle write and issue.
//  - Write: on rising edge, if wb_we && wb_waddr!=0, then reg[wb_waddr] <= wb_wdata. Writes to r0 are dropped.
//  - Read: combinational, zero latency. r0 always reads 0.
//  - Bypass: if wb_we && wb_waddr==addr && addr!=0, the port returns wb_wdata (write-first).
//  - pend(r) = cnt[r]!=0 && !(cnt[r]==1 && wb_we && wb_waddr==r). The last outstanding write is covered by the bypass.
//  - full = id_issue && id_dst_we && id_dst!=0 && cnt[id_dst]==2**CW-1 && !(wb_we && wb_waddr==id_dst).
//  - stall = (rs_use && pend(rs_addr)) | (rt_use && pend(rt_addr)) | full. Purely combinational.
//  - inc[r] = id_issue && !stall && id_dst_we && id_dst==r && r!=0.
//  - dec[r] = wb_we && wb_waddr==r && r!=0.
//  - cnt[r] next value:
//      inc and dec in the same cycle -> unchanged.
//      inc only -> +1.
//      dec only -> -1.
//  - dec with cnt==0 -> counter stays 0 and sb_err<=1. The write still updates the register.
//  - Overflow is impossible while stall gates inc. Any inc at max sets sb_err and the counter saturates.
//  - sb_err clears only on rst.
//  - r0 counter is constant 0 and never contributes to stall.
//  - Reset mid-operation: all pending state is discarded. The pipeline must flush alongside.
// STRUCTURE
//  - Shared package mips_pkg: AW, DW, NREG, REG_ZERO=5'd0, and the regaddr_t/word_t typedefs.
//  - Sub-module sb_counter: one CW-bit up/down counter per register.
//      Inputs: inc, dec. Outputs: cnt, err. Instantiated NREG-1 times via generate.
//  - Storage array, bypass muxes, stall logic and sb_err register live in the top.
// TESTING
//  - Reset: pulse rst with wb_we=1 on r5 -> r5 reads 0, stall=0, sb_err=0.
//  - Write/read: wb_we, r3<=32'hDEADBEEF -> next cycle rs_addr=3 gives DEADBEEF.
//      Write to r0 -> r0 still reads 0.
//  - Bypass: same-cycle wb_we r7<=32'h12345678 with rt_addr=7 -> rt_data=12345678 combinationally.
//  - Hazard: issue id_dst=4, then rs_addr=4 rs_use=1 -> stall=1.
//      stall stays 1 until the WB write to r4 cycle, where stall=0 and data is bypassed.
//  - Multi-flight: three issues to r9, then a fourth -> stall=1 (full).
//      Three WB writes drain the counter to 0. Issue+WB to r9 in the same cycle leaves cnt unchanged.
//  - Error: wb_we to r10 with cnt[10]=0 -> sb_err=1 and sticky.
//      r10 is still written. rst clears sb_err.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-file geometry and the
// address/data types used across the writeback sink.
package mips_pkg;

   localparam int NREG = 32;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int CW   = 2;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef logic [AW-1:0] regaddr_t;
   typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/regfile_wb_sink_sb_counter.sv
// Pending-write counter for one architectural register. It counts issued
// writes that have not yet reached writeback and flags under/overflow.
module sb_counter #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] cnt,
   output logic          err
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   // A simultaneous issue and retire to the same register cancel out.
   always_comb begin
      err = (dec && !inc && cnt == '0) || (inc && !dec && cnt == CNT_MAX);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && !dec && cnt != CNT_MAX) begin
         cnt <= cnt + CW'(1);
      end else if (dec && !inc && cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural register file with write-first bypass and a per-register
// pending-write scoreboard that holds ID until its sources are written back.
module regfile_wb_sink #(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int CW   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_waddr,
   input  logic [DW-1:0] wb_wdata,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   input  logic          rs_use,
   input  logic          rt_use,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   input  logic          id_issue,
   input  logic          id_dst_we,
   input  logic [AW-1:0] id_dst,
   output logic          stall,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic          sb_err
);

   import mips_pkg::*;

   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [DW-1:0]   regs [NREG];
   logic [CW-1:0]   cnt  [NREG];
   logic [NREG-1:0] incVec;
   logic [NREG-1:0] decVec;
   logic [NREG-1:0] errVec;
   logic            rsPend;
   logic            rtPend;
   logic            full;
   logic            sbErrQ;

   // The last outstanding write to a register is satisfied by the bypass.
   function automatic logic pending(input logic [CW-1:0] c, input logic wbHit);
      return (c != '0) && !(c == CW'(1) && wbHit);
   endfunction

   always_comb begin
      rs_data = regs[rs_addr];
      if (rs_addr == REG_ZERO)                  rs_data = '0;
      else if (wb_we && wb_waddr == rs_addr)    rs_data = wb_wdata;

      rt_data = regs[rt_addr];
      if (rt_addr == REG_ZERO)                  rt_data = '0;
      else if (wb_we && wb_waddr == rt_addr)    rt_data = wb_wdata;

      dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];
   end

   always_comb begin
      rsPend = pending(cnt[rs_addr], wb_we && wb_waddr == rs_addr);
      rtPend = pending(cnt[rt_addr], wb_we && wb_waddr == rt_addr);
      full   = id_issue && id_dst_we && id_dst != REG_ZERO &&
               cnt[id_dst] == CNT_MAX && !(wb_we && wb_waddr == id_dst);
      stall  = (rs_use && rsPend) || (rt_use && rtPend) || full;
   end

   assign cnt[0]    = '0;
   assign incVec[0] = 1'b0;
   assign decVec[0] = 1'b0;
   assign errVec[0] = 1'b0;

   for (genvar g = 1; g < NREG; g++) begin : gen_cnt
      assign incVec[g] = id_issue && !stall && id_dst_we && id_dst == AW'(g);
      assign decVec[g] = wb_we && wb_waddr == AW'(g);

      sb_counter #(.CW(CW)) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (incVec[g]),
         .dec (decVec[g]),
         .cnt (cnt[g]),
         .err (errVec[g])
      );
   end

   // NOTE: the storage array is reset explicitly because architectural
   // registers must read zero after reset; this keeps it out of RAM macros.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_we && wb_waddr != REG_ZERO) begin
         regs[wb_waddr] <= wb_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)          sbErrQ <= 1'b0;
      else if (|errVec) sbErrQ <= 1'b1;
   end

   assign sb_err = sbErrQ;

endmodule
